// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: groups the control handshake and the A/B/C buffer
// ports of the matrix-multiply sequencer.
//   mult_start/matrix_size : start level and N from control_unit
//   rd_en/a_addr/b_addr    : operand buffer read request
//   a_data/b_data          : operand read data, one cycle after rd_en
//   c_we/c_addr/c_data     : result buffer write
//   busy/mult_done/size_err: status back to control_unit
// slave is the sequencer's view; master is the environment's view.
interface matmul_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int ADDR_W = 6
) ();
  logic              mult_start;
  logic [3:0]        matrix_size;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [ACC_W-1:0]  c_data;
  logic              busy;
  logic              mult_done;
  logic              size_err;

  modport slave (
    input  mult_start, matrix_size, a_data, b_data,
    output rd_en, a_addr, b_addr, c_we, c_addr, c_data, busy, mult_done, size_err
  );

  modport master (
    output mult_start, matrix_size, a_data, b_data,
    input  rd_en, a_addr, b_addr, c_we, c_addr, c_data, busy, mult_done, size_err
  );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: computes C = A x B for N x N unsigned matrices held in
// row-major operand buffers, one C element at a time (N reads, one drain
// cycle for the last read's data, one write), then pulses mult_done.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : matmul_sequencer_if.slave (start/size in, buffer read/write, status out)
module matmul_sequencer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int MAX_N  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  matmul_sequencer_if.slave bus
);

  localparam int CW = 4;  // counter width follows matrix_size

  typedef enum logic [2:0] {S_IDLE, S_RD, S_DRAIN, S_WR, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       n_q, n_d, i_q, i_d, j_q, j_d, k_q, k_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                rd_valid_q;
  logic                armed_q, armed_d;
  logic                size_err_q, size_err_d;
  logic [2*DATA_W-1:0] prod;
  logic [CW-1:0]       last;
  logic                accept, size_bad;

  assign prod     = (2*DATA_W)'(bus.a_data) * (2*DATA_W)'(bus.b_data);
  assign last     = n_q - CW'(1);
  assign accept   = (state_q == S_IDLE) && bus.mult_start && armed_q;
  assign size_bad = (bus.matrix_size == '0) || (bus.matrix_size > CW'(MAX_N));

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    size_err_d = size_err_q;
    // Re-arm only once the start level has been seen low, so a level held
    // past mult_done cannot launch a second run.
    armed_d    = bus.mult_start ? armed_q : 1'b1;
    // Read data lands one cycle after rd_en; accumulate whenever it is valid.
    acc_d      = rd_valid_q ? acc_q + ACC_W'(prod) : acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          armed_d = 1'b0;
          n_d     = bus.matrix_size;
          if (size_bad) begin
            size_err_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            size_err_d = 1'b0;
            i_d        = '0;
            j_d        = '0;
            k_d        = '0;
            acc_d      = '0;
            state_d    = S_RD;
          end
        end
      end
      S_RD: begin
        if (k_q == last) begin
          k_d     = '0;
          state_d = S_DRAIN;
        end else begin
          k_d = k_q + CW'(1);
        end
      end
      S_DRAIN: state_d = S_WR;
      S_WR: begin
        acc_d = '0;
        if (j_q == last) begin
          j_d = '0;
          i_d = i_q + CW'(1);
        end else begin
          j_d = j_q + CW'(1);
        end
        state_d = (i_q == last && j_q == last) ? S_DONE : S_RD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      rd_valid_q <= 1'b0;
      armed_q    <= 1'b1;
      size_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      rd_valid_q <= (state_q == S_RD);
      armed_q    <= armed_d;
      size_err_q <= size_err_d;
    end
  end

  // All outputs decode registered state only; nothing flows from inputs.
  assign bus.rd_en     = (state_q == S_RD);
  assign bus.c_we      = (state_q == S_WR);
  assign bus.mult_done = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.size_err  = size_err_q;
  assign bus.a_addr    = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(k_q);
  assign bus.b_addr    = ADDR_W'(k_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
  assign bus.c_addr    = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
  assign bus.c_data    = acc_q;

endmodule
